nvdla_dbb_wr_bridge: RTL and testbench
======================================

NVDLA_DBB_WR_BRIDGE -- requirements
Module: nvdla_dbb_wr_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: write address width.
REQ-002 SHALL have parameter DATA_W, default 64: write data width, power of two, 32..512.
REQ-003 SHALL have parameter MAX_OUT, default 8: maximum outstanding write bursts, 1..15.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have ports s_awvalid/s_awready, input/output, 1 each: write-address handshake from the NVDLA core data-backbone master.
REQ-007 SHALL have ports s_awid, input, 8; s_awlen, input, 4; s_awaddr, input, ADDR_W: burst ID, beats-1, and start address.
REQ-008 SHALL have ports s_wvalid/s_wready/s_wlast, 1 each; s_wdata, input, DATA_W; s_wstrb, input, DATA_W/8: core write data.
REQ-009 SHALL have ports s_bvalid/s_bready, 1 each; s_bid, output, 8: write response to the core.
REQ-010 SHALL have ports m_awvalid/m_awready, m_awid 8, m_awaddr ADDR_W, m_awlen 8, m_awsize 3, m_awburst 2, m_awcache 4, m_awprot 3: AXI4 write address to the interconnect.
REQ-011 SHALL have ports m_wvalid/m_wready/m_wlast, m_wdata DATA_W, m_wstrb DATA_W/8: AXI4 write data.
REQ-012 SHALL have ports m_bvalid/m_bready, m_bid 8, m_bresp 2: AXI4 write response.
REQ-013 SHALL have port err_clr, input, 1 (pulse, clears sticky errors), and port err, output, 2 (sticky error flags).

Function
REQ-014 SHALL register AW in a 2-entry FIFO: s_awready = FIFO not full; m_aw* driven from the FIFO head; minimum latency of 1 cycle from s_aw handshake to m_awvalid.
REQ-015 SHALL drive m_awlen = {4'b0, s_awlen}, m_awsize = log2(DATA_W/8), m_awburst = 2'b01, m_awcache = 4'b0011, and m_awprot = 3'b000.
REQ-016 SHALL keep an outstanding counter: +1 on m_aw handshake, -1 on m_b handshake, unchanged when both occur in the same cycle.
REQ-017 SHALL hold m_awvalid low while outstanding == MAX_OUT; the head entry SHALL remain unchanged.
REQ-018 SHALL keep a W-credit counter: +1 on m_aw handshake, -1 on a W handshake with wlast; both in the same cycle SHALL leave it unchanged.
REQ-019 SHALL set m_wvalid = s_wvalid and s_wready = m_wready only while W-credit > 0; otherwise both SHALL be 0; W payload SHALL pass combinationally.
REQ-020 SHALL pass B combinationally: s_bvalid = m_bvalid, m_bready = s_bready, s_bid = m_bid.
REQ-021 SHALL set err[0] on any m_b handshake with m_bresp != 2'b00; err[0] SHALL be sticky until err_clr.
REQ-022 SHALL give a set event priority over err_clr in the same cycle.
REQ-023 SHALL never underflow: a m_b handshake with outstanding == 0 SHALL leave the counter at 0 and set err[0].

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear both FIFOs, the outstanding counter, the W-credit counter, the beat counter, and err.
REQ-025 SHALL hold m_awvalid, m_wvalid, and s_awready at 0 during reset; s_awready SHALL rise in the first cycle after reset release.
REQ-026 SHALL, on reset mid-burst, drop pending bursts without completing them.

Configuration
REQ-027 SHALL implement beat checking under macro NVDLA_DBB_WR_LEN_CHK_EN. When defined, a MAX_OUT-deep FIFO of awlen, pushed on m_aw handshake, plus a beat counter SHALL set sticky err[1] when wlast arrives on beat != awlen+1 or is missing on beat awlen+1.
REQ-028 SHALL, when NVDLA_DBB_WR_LEN_CHK_EN is undefined, omit the length FIFO and beat counter and tie err[1] to 0.

Verification
REQ-029 SHALL pass: single AW (id 3, len 3, addr 0x1000), then 4 W beats -> m_awlen=8'd3, m_awsize=3, m_awburst=1; W passes only after the m_aw handshake; s_bid=3 on B.
REQ-030 SHALL pass: 9 AWs with m_bvalid held 0 and MAX_OUT=8 -> exactly 8 m_aw handshakes; 9th released 1 cycle after the first B handshake.
REQ-031 SHALL pass: s_wvalid asserted before any AW -> s_wready=0 and m_wvalid=0 until the AW is accepted downstream.
REQ-032 SHALL pass: B with m_bresp=2'b10 on the same cycle as err_clr -> err[0]=1 afterwards; err_clr alone next cycle -> err[0]=0.
REQ-033 SHALL pass, with the macro defined: AW len 3, wlast on beat 2 -> err[1]=1; with the macro undefined, the same stimulus -> err[1]=0.
REQ-034 SHALL pass: reset_n pulsed low mid-burst, after 2 of 4 beats -> all outputs at reset values that cycle; a new burst after reset completes normally.

Source files
------------

// File: rtl/nvdla_dbb_wr_bridge.sv
// Write-channel bridge from the NVDLA data backbone to AXI4: buffers AW, limits outstanding bursts, gates W per accepted AW.
// Optional burst-length checking is built when NVDLA_DBB_WR_LEN_CHK_EN is defined; otherwise err[1] is tied low.
module nvdla_dbb_wr_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [7:0]          s_awid,
  input  logic [3:0]          s_awlen,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic                s_wlast,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [7:0]          s_bid,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [7:0]          m_awid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic                m_wlast,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [7:0]          m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                err_clr,
  output logic [1:0]          err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam int CRD_W  = OUT_W + 1;
  localparam logic [2:0] AW_SIZE = 3'($clog2(STRB_W));

  typedef struct packed {
    logic [7:0]        id;
    logic [3:0]        len;
    logic [ADDR_W-1:0] addr;
  } aw_entry_t;

  aw_entry_t         aw_mem [2];
  logic              aw_wr_ptr_reg;
  logic              aw_rd_ptr_reg;
  logic [1:0]        aw_count_reg;
  logic              ready_en_reg;
  logic              aw_full;
  logic              aw_empty;
  aw_entry_t         aw_head;
  logic              s_aw_hs;
  logic              m_aw_hs;
  logic              w_hs;
  logic              w_last_hs;
  logic              m_b_hs;
  logic              out_zero;
  logic [OUT_W-1:0]  outstanding_reg;
  logic [OUT_W-1:0]  outstanding_next;
  logic [CRD_W-1:0]  credit_reg;
  logic [CRD_W-1:0]  credit_next;
  logic              w_open;
  logic              err0_reg;
  logic              err0_set;
  logic              err1;

  assign aw_full   = (aw_count_reg == 2'd2);
  assign aw_empty  = (aw_count_reg == 2'd0);
  assign aw_head   = aw_mem[aw_rd_ptr_reg];

  // ready_en keeps s_awready low while in reset and for the release cycle
  assign s_awready = ready_en_reg && !aw_full;
  assign s_aw_hs   = s_awvalid && s_awready;

  assign m_awvalid = !aw_empty && (outstanding_reg < OUT_W'(MAX_OUT));
  assign m_aw_hs   = m_awvalid && m_awready;
  assign m_awid    = aw_head.id;
  assign m_awaddr  = aw_head.addr;
  assign m_awlen   = {4'b0000, aw_head.len};
  assign m_awsize  = AW_SIZE;
  assign m_awburst = 2'b01;
  assign m_awcache = 4'b0011;
  assign m_awprot  = 3'b000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_reg  <= 1'b0;
      aw_wr_ptr_reg <= 1'b0;
      aw_rd_ptr_reg <= 1'b0;
      aw_count_reg  <= 2'd0;
      aw_mem[0]     <= '0;
      aw_mem[1]     <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (s_aw_hs) begin
        aw_mem[aw_wr_ptr_reg] <= {s_awid, s_awlen, s_awaddr};
        aw_wr_ptr_reg         <= ~aw_wr_ptr_reg;
      end
      if (m_aw_hs) begin
        aw_rd_ptr_reg <= ~aw_rd_ptr_reg;
      end
      case ({s_aw_hs, m_aw_hs})
        2'b10:   aw_count_reg <= aw_count_reg + 2'd1;
        2'b01:   aw_count_reg <= aw_count_reg - 2'd1;
        default: aw_count_reg <= aw_count_reg;
      endcase
    end
  end

  // B path is a straight wire; only the handshake is observed
  assign s_bvalid = m_bvalid;
  assign m_bready = s_bready;
  assign s_bid    = m_bid;
  assign m_b_hs   = m_bvalid && s_bready;
  assign out_zero = (outstanding_reg == '0);

  always_comb begin
    outstanding_next = outstanding_reg;
    if (m_aw_hs && !m_b_hs) begin
      outstanding_next = outstanding_reg + 1'b1;
    end else if (!m_aw_hs && m_b_hs && !out_zero) begin
      outstanding_next = outstanding_reg - 1'b1;
    end
  end

  // W is only let through for bursts whose address already went downstream
  assign w_open    = (credit_reg != '0);
  assign m_wvalid  = s_wvalid && w_open;
  assign s_wready  = m_wready && w_open;
  assign m_wlast   = s_wlast;
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign w_hs      = m_wvalid && m_wready;
  assign w_last_hs = w_hs && s_wlast;

  always_comb begin
    credit_next = credit_reg;
    if (m_aw_hs && !w_last_hs && (credit_reg != {CRD_W{1'b1}})) begin
      credit_next = credit_reg + 1'b1;
    end else if (!m_aw_hs && w_last_hs) begin
      credit_next = credit_reg - 1'b1;
    end
  end

  // A response with nothing outstanding is treated as an error too
  assign err0_set = m_b_hs && ((m_bresp != 2'b00) || out_zero);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_reg <= '0;
      credit_reg      <= '0;
      err0_reg        <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      credit_reg      <= credit_next;
      if (err0_set) begin
        err0_reg <= 1'b1;
      end else if (err_clr) begin
        err0_reg <= 1'b0;
      end
    end
  end

`ifdef NVDLA_DBB_WR_LEN_CHK_EN
  localparam int LQ_PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int LQ_CNT_W = $clog2(MAX_OUT + 1);

  logic [3:0]          lq_mem [MAX_OUT];
  logic [LQ_PTR_W-1:0] lq_wr_ptr_reg;
  logic [LQ_PTR_W-1:0] lq_rd_ptr_reg;
  logic [LQ_CNT_W-1:0] lq_count_reg;
  logic [3:0]          beat_cnt_reg;
  logic [3:0]          cur_len;
  logic                lq_nonempty;
  logic                lq_push;
  logic                lq_pop;
  logic                len_bad;
  logic                err1_reg;

  assign cur_len     = lq_mem[lq_rd_ptr_reg];
  assign lq_nonempty = (lq_count_reg != '0);
  assign lq_pop      = w_last_hs && lq_nonempty;
  assign lq_push     = m_aw_hs && ((lq_count_reg != LQ_CNT_W'(MAX_OUT)) || lq_pop);
  // beat_cnt is zero-based, so the last beat is the one where it equals awlen
  assign len_bad     = w_hs && lq_nonempty &&
                       (s_wlast ? (beat_cnt_reg != cur_len) : (beat_cnt_reg == cur_len));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lq_wr_ptr_reg <= '0;
      lq_rd_ptr_reg <= '0;
      lq_count_reg  <= '0;
      beat_cnt_reg  <= '0;
      err1_reg      <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) begin
        lq_mem[i] <= '0;
      end
    end else begin
      if (lq_push) begin
        lq_mem[lq_wr_ptr_reg] <= aw_head.len;
        lq_wr_ptr_reg <= (lq_wr_ptr_reg == LQ_PTR_W'(MAX_OUT - 1)) ? '0 : lq_wr_ptr_reg + 1'b1;
      end
      if (lq_pop) begin
        lq_rd_ptr_reg <= (lq_rd_ptr_reg == LQ_PTR_W'(MAX_OUT - 1)) ? '0 : lq_rd_ptr_reg + 1'b1;
      end
      case ({lq_push, lq_pop})
        2'b10:   lq_count_reg <= lq_count_reg + 1'b1;
        2'b01:   lq_count_reg <= lq_count_reg - 1'b1;
        default: lq_count_reg <= lq_count_reg;
      endcase
      if (w_hs) begin
        beat_cnt_reg <= s_wlast ? 4'd0 : beat_cnt_reg + 4'd1;
      end
      if (len_bad) begin
        err1_reg <= 1'b1;
      end else if (err_clr) begin
        err1_reg <= 1'b0;
      end
    end
  end

  assign err1 = err1_reg;
`else
  assign err1 = 1'b0;
`endif

  assign err = {err1, err0_reg};

endmodule

// File: tb/tb_nvdla_dbb_wr_bridge.sv
// Directed bench for nvdla_dbb_wr_bridge: each task drives one scenario and compares outputs against hand-computed values.
module tb_nvdla_dbb_wr_bridge;

`ifdef NVDLA_DBB_WR_LEN_CHK_EN
  localparam logic LEN_ERR_EXP = 1'b1;
`else
  localparam logic LEN_ERR_EXP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        s_awvalid, s_awready;
  logic [7:0]  s_awid;
  logic [3:0]  s_awlen;
  logic [31:0] s_awaddr;
  logic        s_wvalid, s_wready, s_wlast;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [7:0]  s_bid;
  logic        m_awvalid, m_awready;
  logic [7:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic [3:0]  m_awcache;
  logic [2:0]  m_awprot;
  logic        m_wvalid, m_wready, m_wlast;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [7:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        err_clr;
  logic [1:0]  err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  nvdla_dbb_wr_bridge dut (
    .clk(clk), .reset_n(reset_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awlen(s_awlen), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .err_clr(err_clr), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    s_wvalid = 1'b1;
    #12;
    vec_cnt++; if (s_awready !== 1'b0) begin miss_cnt++; $display("FAIL rst_awready got=%0h exp=0", s_awready); end
    vec_cnt++; if (m_awvalid !== 1'b0) begin miss_cnt++; $display("FAIL rst_m_awvalid got=%0h exp=0", m_awvalid); end
    vec_cnt++; if (m_wvalid !== 1'b0) begin miss_cnt++; $display("FAIL rst_m_wvalid got=%0h exp=0", m_wvalid); end
    vec_cnt++; if (err !== 2'b00) begin miss_cnt++; $display("FAIL rst_err got=%0h exp=0", err); end
    s_wvalid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    vec_cnt++; if (s_awready !== 1'b1) begin miss_cnt++; $display("FAIL rst_release_awready got=%0h exp=1", s_awready); end
    $display("reset: released, s_awready=%0h", s_awready);
  endtask

  task automatic test_single_burst(input logic [7:0] id, input logic [31:0] addr);
    logic [63:0] exp_d;
    s_awvalid = 1'b1; s_awid = id; s_awlen = 4'd3; s_awaddr = addr;
    s_wvalid = 1'b1; s_wdata = 64'hDEAD; s_wstrb = 8'hFF; s_wlast = 1'b0;
    #1;
    vec_cnt++; if (s_awready !== 1'b1) begin miss_cnt++; $display("FAIL single_awready got=%0h exp=1", s_awready); end
    vec_cnt++; if (s_wready !== 1'b0 || m_wvalid !== 1'b0) begin miss_cnt++; $display("FAIL single_w_early got=%0h/%0h exp=0/0", s_wready, m_wvalid); end
    tick();
    s_awvalid = 1'b0;
    #1;
    vec_cnt++; if (m_awvalid !== 1'b1) begin miss_cnt++; $display("FAIL single_m_awvalid got=%0h exp=1", m_awvalid); end
    vec_cnt++; if (m_awid !== id) begin miss_cnt++; $display("FAIL single_awid got=%0h exp=%0h", m_awid, id); end
    vec_cnt++; if (m_awaddr !== addr) begin miss_cnt++; $display("FAIL single_awaddr got=%0h exp=%0h", m_awaddr, addr); end
    vec_cnt++; if (m_awlen !== 8'd3) begin miss_cnt++; $display("FAIL single_awlen got=%0h exp=3", m_awlen); end
    vec_cnt++; if (m_awsize !== 3'd3) begin miss_cnt++; $display("FAIL single_awsize got=%0h exp=3", m_awsize); end
    vec_cnt++; if (m_awburst !== 2'd1) begin miss_cnt++; $display("FAIL single_awburst got=%0h exp=1", m_awburst); end
    vec_cnt++; if (m_awcache !== 4'b0011 || m_awprot !== 3'b000) begin miss_cnt++; $display("FAIL single_cache_prot got=%0h/%0h exp=3/0", m_awcache, m_awprot); end
    vec_cnt++; if (s_wready !== 1'b0) begin miss_cnt++; $display("FAIL single_w_before_hs got=%0h exp=0", s_wready); end
    tick();
    vec_cnt++; if (m_awvalid !== 1'b0) begin miss_cnt++; $display("FAIL single_awvalid_after got=%0h exp=0", m_awvalid); end
    for (int b = 0; b < 4; b++) begin
      exp_d = 64'hCAFE_0000_0000_0000 + 64'(b);
      s_wdata = exp_d; s_wlast = (b == 3);
      #1;
      vec_cnt++; if (m_wvalid !== 1'b1 || s_wready !== 1'b1) begin miss_cnt++; $display("FAIL single_beat%0d_valid got=%0h/%0h exp=1/1", b, m_wvalid, s_wready); end
      vec_cnt++; if (m_wdata !== exp_d || m_wlast !== (b == 3)) begin miss_cnt++; $display("FAIL single_beat%0d_data got=%0h/%0h exp=%0h/%0h", b, m_wdata, m_wlast, exp_d, (b == 3)); end
      $display("burst id=%0h beat %0d data=%0h last=%0h", id, b, m_wdata, m_wlast);
      tick();
    end
    #1;
    vec_cnt++; if (s_wready !== 1'b0 || m_wvalid !== 1'b0) begin miss_cnt++; $display("FAIL single_credit_done got=%0h/%0h exp=0/0", s_wready, m_wvalid); end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    m_bvalid = 1'b1; m_bid = id; m_bresp = 2'b00;
    #1;
    vec_cnt++; if (s_bvalid !== 1'b1 || s_bid !== id) begin miss_cnt++; $display("FAIL single_b got=%0h/%0h exp=1/%0h", s_bvalid, s_bid, id); end
    tick();
    m_bvalid = 1'b0;
    #1;
    vec_cnt++; if (err !== 2'b00) begin miss_cnt++; $display("FAIL single_err got=%0h exp=0", err); end
  endtask

  task automatic test_max_out;
    int acc = 0;
    int hs  = 0;
    for (int c = 0; c < 30; c++) begin
      s_awvalid = (acc < 9); s_awid = 8'(acc); s_awlen = 4'd0; s_awaddr = 32'(acc) << 6;
      #1;
      if (s_awvalid && s_awready) acc++;
      if (m_awvalid && m_awready) hs++;
      tick();
    end
    s_awvalid = 1'b0;
    #1;
    vec_cnt++; if (acc !== 9) begin miss_cnt++; $display("FAIL maxout_accepted got=%0d exp=9", acc); end
    vec_cnt++; if (hs !== 8) begin miss_cnt++; $display("FAIL maxout_handshakes got=%0d exp=8", hs); end
    m_bvalid = 1'b1; m_bid = 8'd0; m_bresp = 2'b00;
    #1;
    vec_cnt++; if (m_awvalid !== 1'b0) begin miss_cnt++; $display("FAIL maxout_gated got=%0h exp=0", m_awvalid); end
    tick();
    m_bvalid = 1'b0;
    #1;
    vec_cnt++; if (m_awvalid !== 1'b1 || m_awid !== 8'd8) begin miss_cnt++; $display("FAIL maxout_release got=%0h/%0h exp=1/8", m_awvalid, m_awid); end
    $display("max_out: %0d handshakes, 9th released id=%0h", hs, m_awid);
    tick();
    s_wvalid = 1'b1; s_wlast = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    #1;
    vec_cnt++; if (m_wvalid !== 1'b0) begin miss_cnt++; $display("FAIL maxout_credit_empty got=%0h exp=0", m_wvalid); end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    m_bvalid = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    m_bvalid = 1'b0;
    #1;
    vec_cnt++; if (err !== 2'b00) begin miss_cnt++; $display("FAIL maxout_err got=%0h exp=0", err); end
  endtask

  task automatic test_w_before_aw;
    m_awready = 1'b0;
    s_wvalid = 1'b1; s_wlast = 1'b1; s_wdata = 64'h77;
    for (int c = 0; c < 3; c++) begin
      #1;
      vec_cnt++; if (s_wready !== 1'b0 || m_wvalid !== 1'b0) begin miss_cnt++; $display("FAIL wfirst_noaw%0d got=%0h/%0h exp=0/0", c, s_wready, m_wvalid); end
      tick();
    end
    s_awvalid = 1'b1; s_awid = 8'd7; s_awlen = 4'd0; s_awaddr = 32'h4000;
    tick();
    s_awvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      vec_cnt++; if (m_awvalid !== 1'b1 || s_wready !== 1'b0 || m_wvalid !== 1'b0) begin miss_cnt++; $display("FAIL wfirst_stall%0d got=%0h/%0h/%0h exp=1/0/0", c, m_awvalid, s_wready, m_wvalid); end
      tick();
    end
    m_awready = 1'b1;
    #1;
    vec_cnt++; if (s_wready !== 1'b0) begin miss_cnt++; $display("FAIL wfirst_hs_cycle got=%0h exp=0", s_wready); end
    tick();
    vec_cnt++; if (s_wready !== 1'b1 || m_wvalid !== 1'b1) begin miss_cnt++; $display("FAIL wfirst_open got=%0h/%0h exp=1/1", s_wready, m_wvalid); end
    $display("w_before_aw: W opened after downstream AW, s_wready=%0h", s_wready);
    tick();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    m_bvalid = 1'b1; m_bid = 8'd7; m_bresp = 2'b00;
    tick();
    m_bvalid = 1'b0;
  endtask

  task automatic test_err;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    s_awvalid = 1'b1; s_awid = 8'd9; s_awlen = 4'd0; s_awaddr = 32'h5000;
    tick();
    s_awvalid = 1'b0;
    tick();
    s_wvalid = 1'b1; s_wlast = 1'b1;
    tick();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    #1;
    vec_cnt++; if (err !== 2'b00) begin miss_cnt++; $display("FAIL err_baseline got=%0h exp=0", err); end
    m_bvalid = 1'b1; m_bid = 8'd9; m_bresp = 2'b10; err_clr = 1'b1;
    tick();
    m_bvalid = 1'b0; m_bresp = 2'b00; err_clr = 1'b0;
    #1;
    vec_cnt++; if (err[0] !== 1'b1) begin miss_cnt++; $display("FAIL err_set_over_clr got=%0h exp=1", err[0]); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    vec_cnt++; if (err[0] !== 1'b0) begin miss_cnt++; $display("FAIL err_clear got=%0h exp=0", err[0]); end
    m_bvalid = 1'b1; m_bresp = 2'b00;
    tick();
    m_bvalid = 1'b0;
    #1;
    vec_cnt++; if (err[0] !== 1'b1) begin miss_cnt++; $display("FAIL err_underflow got=%0h exp=1", err[0]); end
    $display("err: slverr and underflow flagged, err=%0h", err);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_len;
    s_awvalid = 1'b1; s_awid = 8'd4; s_awlen = 4'd3; s_awaddr = 32'h6000;
    tick();
    s_awvalid = 1'b0;
    tick();
    s_wvalid = 1'b1; s_wlast = 1'b0;
    tick();
    s_wlast = 1'b1;
    tick();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    #1;
    vec_cnt++; if (s_wready !== 1'b0) begin miss_cnt++; $display("FAIL len_credit got=%0h exp=0", s_wready); end
    vec_cnt++; if (err !== {LEN_ERR_EXP, 1'b0}) begin miss_cnt++; $display("FAIL len_err got=%0h exp=%0h", err, {LEN_ERR_EXP, 1'b0}); end
    $display("len_chk: early wlast on beat 2, err=%0h", err);
    m_bvalid = 1'b1; m_bid = 8'd4; m_bresp = 2'b00;
    tick();
    m_bvalid = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    vec_cnt++; if (err !== 2'b00) begin miss_cnt++; $display("FAIL len_clear got=%0h exp=0", err); end
  endtask

  task automatic test_reset_mid;
    s_awvalid = 1'b1; s_awid = 8'd6; s_awlen = 4'd3; s_awaddr = 32'h3000;
    tick();
    s_awvalid = 1'b0;
    tick();
    s_wvalid = 1'b1; s_wlast = 1'b0;
    tick();
    tick();
    s_awvalid = 1'b1; s_awid = 8'd1;
    reset_n = 1'b0;
    #1;
    vec_cnt++; if (s_awready !== 1'b0 || m_awvalid !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_aw got=%0h/%0h exp=0/0", s_awready, m_awvalid); end
    vec_cnt++; if (m_wvalid !== 1'b0 || s_wready !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_w got=%0h/%0h exp=0/0", m_wvalid, s_wready); end
    vec_cnt++; if (err !== 2'b00) begin miss_cnt++; $display("FAIL rstmid_err got=%0h exp=0", err); end
    s_awvalid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    vec_cnt++; if (s_awready !== 1'b1 || m_awvalid !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_release got=%0h/%0h exp=1/0", s_awready, m_awvalid); end
    vec_cnt++; if (m_wvalid !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_dropped got=%0h exp=0", m_wvalid); end
    $display("reset_mid: burst dropped, m_wvalid=%0h", m_wvalid);
    s_wvalid = 1'b0;
    test_single_burst(8'd5, 32'h2000);
  endtask

  initial begin
    reset_n = 1'b0;
    s_awvalid = 1'b0; s_awid = '0; s_awlen = '0; s_awaddr = '0;
    s_wvalid = 1'b0; s_wlast = 1'b0; s_wdata = '0; s_wstrb = 8'hFF;
    s_bready = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1;
    m_bvalid = 1'b0; m_bid = '0; m_bresp = 2'b00;
    err_clr = 1'b0;
    test_reset();
    test_single_burst(8'd3, 32'h1000);
    test_max_out();
    test_w_before_aw();
    test_err();
    test_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
